// File: rtl/mandelbrot_pixel_writer_pkg.sv
// Shared types, FSM states and the iteration-count to RGB332 colour map for the pixel writer.
package mandelbrot_pixel_writer_pkg;

    localparam int unsigned IterW   = 11;
    localparam int unsigned CoordW  = 10;
    localparam int unsigned AddrW   = 19;
    localparam int unsigned EntryW  = IterW + 2 * CoordW;

    localparam logic [7:0] ColourInSet = 8'h00;
    localparam logic [7:0] ColourBand1 = 8'hE0;
    localparam logic [7:0] ColourBand2 = 8'hEC;
    localparam logic [7:0] ColourBand3 = 8'hFC;
    localparam logic [7:0] ColourBand4 = 8'h1C;
    localparam logic [7:0] ColourBand5 = 8'h1F;
    localparam logic [7:0] ColourBand6 = 8'h03;
    localparam logic [7:0] ColourBand7 = 8'h92;
    localparam logic [7:0] ColourFar   = 8'h49;

    typedef enum logic [1:0] {StIdle, StSetup, StWrite} state_e;

    typedef struct packed {
        logic [IterW-1:0]  num_iter;
        logic [CoordW-1:0] x;
        logic [CoordW-1:0] y;
    } result_t;

    // Bands compare against max_iter halved k times; the first (largest) threshold met wins.
    function automatic logic [7:0] colour_map(input logic [IterW-1:0] num_iter,
                                              input logic [31:0] max_iter);
        logic [31:0] n;
        logic [7:0]  colour;
        n = {21'd0, num_iter};
        if (n >= max_iter)             colour = ColourInSet;
        else if (n >= (max_iter >> 1)) colour = ColourBand1;
        else if (n >= (max_iter >> 2)) colour = ColourBand2;
        else if (n >= (max_iter >> 3)) colour = ColourBand3;
        else if (n >= (max_iter >> 4)) colour = ColourBand4;
        else if (n >= (max_iter >> 5)) colour = ColourBand5;
        else if (n >= (max_iter >> 6)) colour = ColourBand6;
        else if (n >= (max_iter >> 7)) colour = ColourBand7;
        else                           colour = ColourFar;
        return colour;
    endfunction

endpackage

// File: rtl/mandelbrot_pixel_writer_fifo.sv
// Result FIFO: synchronous push/pop, full/empty flags and a registered read port loaded on pop.
module mandelbrot_pixel_writer_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [PtrW:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    // A push into a full FIFO is lost even if a pop frees a slot in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok) begin
                rptr_q  <= rptr_q + 1'b1;
                rdata_q <= mem_q[rptr_q];
            end
            count_q <= count_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mandelbrot_pixel_writer.sv
// Buffers iterator results, colours them and writes one RGB332 byte per pixel into the VGA SRAM.
// Optional drop_count statistics port is enabled by defining PIXEL_WRITER_DROP_STATS_EN.
module mandelbrot_pixel_writer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned SRAM_WR_CYCLES = 2,
    parameter int unsigned H_RES          = 640,
    parameter int unsigned V_RES          = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fin_val,
    input  logic [10:0] single_num_iter,
    input  logic [9:0]  single_x,
    input  logic [9:0]  single_y,
    input  logic [31:0] max_iter,
    output logic        in_ready,
    output logic [18:0] sram_address,
    output logic [7:0]  sram_writedata,
    output logic        sram_write,
    output logic        busy,
    output logic        frame_done,
`ifdef PIXEL_WRITER_DROP_STATS_EN
    output logic [15:0] drop_count,
`endif
    output logic [15:0] frame_count
);

    import mandelbrot_pixel_writer_pkg::*;

    localparam int unsigned FbPixels = H_RES * V_RES;

    result_t          fifo_wdata;
    result_t          fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    state_e           state_q, state_d;
    logic [1:0]       wr_cnt_q, wr_cnt_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [AddrW-1:0] pix_cnt_q, pix_cnt_d;
    logic [AddrW-1:0] pix_cnt_inc;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             pix_valid;
    logic [AddrW-1:0] pix_addr;

    assign fifo_wdata = '{num_iter: single_num_iter, x: single_x, y: single_y};

    mandelbrot_pixel_writer_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EntryW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fin_val),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pix_valid   = ({22'd0, fifo_rdata.x} < H_RES) && ({22'd0, fifo_rdata.y} < V_RES);
    // y*640 as two shifts keeps the address path multiplier-free.
    assign pix_addr    = (AddrW'(fifo_rdata.y) << 9) + (AddrW'(fifo_rdata.y) << 7)
                       + AddrW'(fifo_rdata.x);
    assign pix_cnt_inc = pix_cnt_q + 19'd1;

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        fifo_pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                if (pix_valid) begin
                    addr_d   = pix_addr;
                    data_d   = colour_map(fifo_rdata.num_iter, max_iter);
                    wr_cnt_d = '0;
                    state_d  = StWrite;
                    if ({13'd0, pix_cnt_inc} == FbPixels) begin
                        pix_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end else begin
                        pix_cnt_d = pix_cnt_inc;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                if ({30'd0, wr_cnt_q} == SRAM_WR_CYCLES - 1) state_d = StIdle;
                else                                         wr_cnt_d = wr_cnt_q + 2'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_cnt_q     <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef PIXEL_WRITER_DROP_STATS_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)                                          drop_cnt_q <= '0;
        else if (fin_val && fifo_full && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign drop_count = drop_cnt_q;
`endif

    assign in_ready       = !fifo_full;
    assign sram_write     = (state_q == StWrite);
    assign sram_address   = addr_q;
    assign sram_writedata = data_q;
    assign busy           = !fifo_empty || (state_q != StIdle);
    assign frame_done     = frame_done_q;
    assign frame_count    = frame_cnt_q;

endmodule

// File: tb/tb_mandelbrot_pixel_writer.sv
// Scoreboard bench: randomized results against a reference colour/address model, plus a
// small-frame instance for frame_done/frame_count. Honours PIXEL_WRITER_DROP_STATS_EN.
module tb_mandelbrot_pixel_writer;

    localparam int W = 2;
    localparam logic [7:0] Band [8] = '{8'h00, 8'hE0, 8'hEC, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'h92};

    typedef struct packed {
        logic [18:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fin_val, fin_s;
    logic [10:0] n_i, n_s;
    logic [9:0]  x_i, y_i, x_s, y_s;
    logic [31:0] max_iter, max_iter_s;
    logic        in_ready, sram_write, busy, frame_done;
    logic        in_ready_s, wr_s, busy_s, fd_s;
    logic [18:0] sram_address, addr_s;
    logic [7:0]  sram_writedata, data_s;
    logic [15:0] frame_count, fc_s;
`ifdef PIXEL_WRITER_DROP_STATS_EN
    logic [15:0] drop_count, drop_count_s;
`endif

    int   checks = 0;
    int   errors = 0;
    int   drops  = 0;
    exp_t exp_q[$];
    exp_t exp_s[$];

    always #5 clk = ~clk;

    mandelbrot_pixel_writer #(
        .FIFO_DEPTH(4), .SRAM_WR_CYCLES(W), .H_RES(640), .V_RES(480)
    ) dut (
        .clk(clk), .reset(reset), .fin_val(fin_val), .single_num_iter(n_i),
        .single_x(x_i), .single_y(y_i), .max_iter(max_iter), .in_ready(in_ready),
        .sram_address(sram_address), .sram_writedata(sram_writedata),
        .sram_write(sram_write), .busy(busy), .frame_done(frame_done),
`ifdef PIXEL_WRITER_DROP_STATS_EN
        .drop_count(drop_count),
`endif
        .frame_count(frame_count)
    );

    mandelbrot_pixel_writer #(
        .FIFO_DEPTH(4), .SRAM_WR_CYCLES(W), .H_RES(4), .V_RES(2)
    ) dut_small (
        .clk(clk), .reset(reset), .fin_val(fin_s), .single_num_iter(n_s),
        .single_x(x_s), .single_y(y_s), .max_iter(max_iter_s), .in_ready(in_ready_s),
        .sram_address(addr_s), .sram_writedata(data_s),
        .sram_write(wr_s), .busy(busy_s), .frame_done(fd_s),
`ifdef PIXEL_WRITER_DROP_STATS_EN
        .drop_count(drop_count_s),
`endif
        .frame_count(fc_s)
    );

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] ref_colour(input int unsigned n, input int unsigned m);
        if (n >= m) return 8'h00;
        for (int k = 1; k <= 7; k++) if (n >= (m >> k)) return Band[k];
        return 8'h49;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one result for the current cycle; acceptance follows the in_ready handshake.
    task automatic send(input int n, input int x, input int y, output bit acc);
        fin_val = 1'b1;
        n_i = 11'(n);
        x_i = 10'(x);
        y_i = 10'(y);
        acc = in_ready;
        if (acc) begin
            if (x < 640 && y < 480) exp_q.push_back({19'(y * 640 + x), ref_colour(n, max_iter)});
        end else begin
            drops++;
        end
        tick();
        fin_val = 1'b0;
    endtask

    task automatic send_s(input int x, input int y);
        fin_s = 1'b1;
        n_s = 11'($urandom_range(0, 2047));
        x_s = 10'(x);
        y_s = 10'(y);
        check("small_in_ready", in_ready_s, 1);
        if (x < 4 && y < 2) exp_s.push_back({19'(y * 640 + x), 8'h00});
        tick();
        fin_s = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        check("drain_in_time", n < 500, 1);
        tick();
    endtask

    // Main scoreboard monitor: one expected entry per write burst.
    logic prev_wr = 1'b0;
    int   run_len = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_wr = 1'b0;
            run_len = 0;
        end else begin
            if (sram_write && !prev_wr) begin
                run_len = 1;
                check("write_was_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("wr_addr", sram_address, cur.addr);
                    check("wr_data", sram_writedata, cur.data);
                end
                check("main_frame_done", frame_done, 0);
            end else if (sram_write) begin
                run_len++;
                check("wr_hold", {sram_address, sram_writedata}, {cur.addr, cur.data});
            end else if (prev_wr) begin
                check("wr_len", run_len, W);
            end
            prev_wr = sram_write;
        end
    end

    // Small-frame monitor: a frame completes on every 8th valid pixel.
    logic prev_s = 1'b0;
    int   writes_s = 0;
    exp_t cur_s;
    always @(negedge clk) begin
        if (reset) begin
            prev_s = 1'b0;
            exp_s.delete();
        end else begin
            if (wr_s && !prev_s) begin
                writes_s++;
                check("small_write_expected", exp_s.size() != 0, 1);
                if (exp_s.size() != 0) begin
                    cur_s = exp_s.pop_front();
                    check("small_addr", {addr_s, data_s}, {cur_s.addr, cur_s.data});
                end
                check("frame_done_pulse", fd_s, (writes_s % 8) == 0);
                check("frame_count", fc_s, writes_s / 8);
            end else if (wr_s) begin
                check("frame_done_width", fd_s, 0);
            end
            prev_s = wr_s;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int accepted;
        int burst_drops;
        reset = 1'b1;
        fin_val = 1'b0;
        fin_s = 1'b0;
        n_i = '0; x_i = '0; y_i = '0;
        n_s = '0; x_s = '0; y_s = '0;
        max_iter = 32'd100;
        max_iter_s = 32'd0;
        repeat (3) tick();

        check("rst_in_ready", in_ready, 1);
        check("rst_sram_write", sram_write, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_address", sram_address, 0);
        check("rst_writedata", sram_writedata, 0);
`ifdef PIXEL_WRITER_DROP_STATS_EN
        check("rst_drop_count", drop_count, 0);
`endif
        reset = 1'b0;
        drops = 0;
        tick();

        // Single pixel latency; 100>>5 = 3 <= 5 selects band 5.
        send(5, 3, 2, acc);
        check("lat_c1_idle", sram_write, 0);
        tick();
        check("lat_c2_setup", sram_write, 0);
        tick();
        check("lat_c3_write", sram_write, 1);
        check("t1_addr", sram_address, 1283);
        check("t1_data", sram_writedata, 8'h1F);
        wait_idle();

        send(100, 639, 479, acc);
        wait_idle();

        // Out-of-range pixel returns to idle two cycles after the pop.
        send(7, 700, 10, acc);
        check("oob_busy_c1", busy, 1);
        tick();
        check("oob_busy_c2", busy, 1);
        tick();
        check("oob_busy_c3", busy, 0);
        check("oob_no_write", sram_write, 0);
        send(7, 10, 480, acc);
        wait_idle();

        // Twenty back-to-back results into a 4-deep FIFO.
        accepted = 0;
        burst_drops = drops;
        for (int i = 0; i < 20; i++) begin
            send($urandom_range(0, 2047), $urandom_range(0, 639), $urandom_range(0, 479), acc);
            if (acc) accepted++;
        end
        check("burst_accepted", accepted, 9);
        check("burst_dropped", drops - burst_drops, 11);
`ifdef PIXEL_WRITER_DROP_STATS_EN
        check("burst_drop_count", drop_count, drops);
`endif
        wait_idle();

        // Push coinciding with a pop while three entries are held must be accepted.
        for (int i = 0; i < 4; i++) send(i * 20, 100 + i, 7, acc);
        tick();
        send(33, 200, 8, acc);
        check("push_pop_at3_accepted", acc, 1);
        check("push_pop_at3_ready", in_ready, 1);
        wait_idle();

        // Random segments, each with its own iteration limit.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg)
                0:       max_iter = 32'd0;
                1:       max_iter = 32'd100;
                2:       max_iter = 32'd2047;
                3:       max_iter = $urandom_range(1, 3000);
                4:       max_iter = 32'hFFFF_FFFF;
                default: max_iter = 32'd1;
            endcase
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 5)) tick();
                send($urandom_range(0, 2047), $urandom_range(0, 700), $urandom_range(0, 520), acc);
            end
            wait_idle();
`ifdef PIXEL_WRITER_DROP_STATS_EN
            check("seg_drop_count", drop_count, drops);
`endif
        end

        // Reset during the second write cycle with three entries still queued.
        max_iter = 32'd50;
        for (int i = 0; i < 4; i++) send(i + 1, 10 + i, 20, acc);
        check("t5_in_second_write", sram_write, 1);
        reset = 1'b1;
        tick();
        check("t5_write_dropped", sram_write, 0);
        check("t5_busy", busy, 0);
        check("t5_in_ready", in_ready, 1);
        reset = 1'b0;
        drops = 0;
        repeat (30) tick();
        check("t5_still_idle", busy, 0);
`ifdef PIXEL_WRITER_DROP_STATS_EN
        check("t5_drop_count_cleared", drop_count, 0);
`endif

        // Small frame: 16 valid pixels interleaved with discarded ones -> two frames.
        for (int i = 0; i < 16; i++) begin
            send_s(i % 4, (i / 4) % 2);
            repeat (5) tick();
            if (i % 3 == 0) begin
                send_s(4 + (i % 5), i % 2);
                repeat (5) tick();
                send_s(i % 4, 2 + (i % 3));
                repeat (5) tick();
            end
        end
        repeat (10) tick();
        check("small_writes", writes_s, 16);
        check("small_frame_count", fc_s, 2);
        check("small_idle", busy_s, 0);
        check("main_frame_count", frame_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
